fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage MIPS pipeline. Holds the PC, drives it onto the
//   combinational instruction memory, captures the returned word into the
//   IF/ID register, and applies stall, branch/jump redirect and exception redirect.
//   Sits between hazard unit / ID-stage branch logic (control) and the decoder (data).
// PARAMETERS
//   PC_RESET    32'h0000_3000  PC value after reset; base of instruction memory
//   IM_WORDS    4096           instruction memory depth in words (legal fetch range)
//   DELAY_SLOT  1              1: instr in IF at redirect is kept (delay slot); 0: squashed
// PORTS
//   clk            in   1   clock, rising edge
//   reset_n        in   1   asynchronous, active-low reset
//   stall          in   1   hazard unit: freeze PC and IF/ID
//   br_redirect    in   1   ID stage: taken branch / j / jal / jr this cycle
//   br_target      in   32  ID stage: redirect target
//   exc_req        in   1   exception or eret commit: redirect and flush
//   exc_target     in   32  handler address (0x0000_4180) or EPC on eret
//   f_instr        in   32  word read from instruction memory at f_pc
//   f_pc           out  32  current fetch PC, to instruction memory
//   d_instr        out  32  IF/ID instruction (0 = nop when bubble / fault)
//   d_pc           out  32  IF/ID PC of d_instr
//   d_pc8          out  32  d_pc + 8 (jal/jalr link value)
//   d_valid        out  1   IF/ID holds a real fetched instruction
//   d_exc_adel     out  1   IF/ID instruction had a fetch address error
// BEHAVIOUR
//   Reset (reset_n low, async): f_pc=PC_RESET; d_instr=0; d_pc=0; d_pc8=8;
//     d_valid=0; d_exc_adel=0. First fetch at PC_RESET on first edge after release.
//   f_pc is the PC register directly (no comb path from inputs to f_pc).
//   Fetch fault (comb, on f_pc): f_pc[1:0]!=0, or f_pc<PC_RESET, or
//     f_pc>=PC_RESET+4*IM_WORDS. Faulting fetch is captured as d_instr=0,
//     d_exc_adel=1, d_valid=1; f_instr ignored.
//   Per rising edge, strict priority:
//   1. exc_req: PC<=exc_target; IF/ID<=bubble (instr 0, valid 0, adel 0).
//      Overrides stall and br_redirect.
//   2. stall: PC and all IF/ID outputs hold. br_redirect ignored this cycle
//      (branch is still in ID and reasserts when stall drops).
//   3. br_redirect: PC<=br_target; IF/ID<=current fetch (DELAY_SLOT=1)
//      or bubble (DELAY_SLOT=0).
//   4. else: PC<=PC+4; IF/ID<=current fetch, d_pc<=f_pc, d_valid<=1.
//   Arithmetic: PC+4 and d_pc+8 are modulo 2^32; 0xFFFF_FFFC+4 wraps to 0
//     (then faults as out-of-range). br_target/exc_target taken unchecked;
//     misalignment is detected when fetched, not at redirect.
//   d_pc8 always equals d_pc+8, including during bubble and reset.
//   Latency: word at f_pc appears on d_instr one edge later (absent stall/exc).
//   Reset asserted mid-stream: immediate return to reset values; no pending
//     redirect survives.
// TESTING
//   T1 reset release, no stall, memory holds 0x3C01_1234 at 0x3000 -> f_pc
//      0x3000,0x3004,0x3008 on successive edges; d_instr=0x3C01_1234,
//      d_pc=0x3000, d_pc8=0x3008, d_valid=1 after edge 1.
//   T2 stall high 3 cycles at f_pc=0x3008 -> f_pc, d_instr, d_pc frozen 3
//      cycles; resumes 0x300C on first edge with stall low.
//   T3 br_redirect, br_target=0x3100 at f_pc=0x3010, DELAY_SLOT=1 -> next
//      f_pc=0x3100, d_pc=0x3010 valid; DELAY_SLOT=0 -> d_valid=0, d_instr=0.
//   T4 exc_req with stall and br_redirect all high, exc_target=0x4180 ->
//      f_pc=0x4180, d_valid=0; stall and branch both ignored.
//   T5 br_target=0x3102 -> next edge d_exc_adel=1, d_instr=0, d_pc=0x3102;
//      br_target=0x2FFC and 0x3000+4*IM_WORDS likewise flagged.
//   T6 reset_n pulsed low between edges during stall with pending redirect ->
//      outputs reset immediately; fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, fetch address check, IF/ID register.
// Redirect priority: exception > stall > branch/jump > sequential.
module fetch_stage #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter int unsigned IM_WORDS   = 4096,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic [31:0] exc_target,
  input  logic [31:0] f_instr,
  output logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        d_valid,
  output logic        d_exc_adel
);

  // 33-bit limit so a memory ending at the top of the address space cannot wrap
  localparam logic [32:0] PcLimit = {1'b0, PC_RESET} + (33'(IM_WORDS) * 33'd4);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] dpc_q, dpc_d;
  logic        valid_q, valid_d;
  logic        adel_q, adel_d;

  logic        fetch_fault;
  logic [31:0] fetch_word;

  always_comb begin
    fetch_fault = (pc_q[1:0] != 2'b00) ||
                  (pc_q < PC_RESET) ||
                  ({1'b0, pc_q} >= PcLimit);
    fetch_word  = fetch_fault ? 32'h0 : f_instr;
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    dpc_d   = dpc_q;
    valid_d = valid_q;
    adel_d  = adel_q;

    if (exc_req) begin
      pc_d    = exc_target;
      instr_d = 32'h0;
      dpc_d   = pc_q;
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end else if (stall) begin
      // The branch stays in ID and reasserts once the stall drops.
    end else begin
      pc_d = br_redirect ? br_target : pc_q + 32'd4;
      if (br_redirect && !DELAY_SLOT) begin
        instr_d = 32'h0;
        dpc_d   = pc_q;
        valid_d = 1'b0;
        adel_d  = 1'b0;
      end else begin
        instr_d = fetch_word;
        dpc_d   = pc_q;
        valid_d = 1'b1;
        adel_d  = fetch_fault;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= PC_RESET;
      instr_q <= 32'h0;
      dpc_q   <= 32'h0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      dpc_q   <= dpc_d;
      valid_q <= valid_d;
      adel_q  <= adel_d;
    end
  end

  assign f_pc       = pc_q;
  assign d_instr    = instr_q;
  assign d_pc       = dpc_q;
  assign d_pc8      = dpc_q + 32'd8;
  assign d_valid    = valid_q;
  assign d_exc_adel = adel_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (delay slot on/off) share stimulus;
// a reference model pushes expected IF state into a scoreboard queue checked after each edge.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        exc_req;
  logic [31:0] exc_target;

  logic [31:0] f_instr1, f_pc1, d_instr1, d_pc1, d_pc81;
  logic        d_valid1, d_adel1;
  logic [31:0] f_instr0, f_pc0, d_instr0, d_pc0, d_pc80;
  logic        d_valid0, d_adel0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] fpc;
    logic [31:0] instr;
    logic [31:0] dpc;
    logic        valid;
    logic        adel;
    logic        chk_pc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state; index 0 = delay slot on, 1 = delay slot off
  logic [31:0] m_pc;
  logic [31:0] m_instr [2];
  logic [31:0] m_dpc   [2];
  logic        m_valid [2];
  logic        m_adel  [2];
  logic        m_chk   [2];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h3C01_1234;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_7000);
  endfunction

  assign f_instr1 = mem_word(f_pc1);
  assign f_instr0 = mem_word(f_pc0);

  fetch_stage #(.PC_RESET(32'h0000_3000), .IM_WORDS(4096), .DELAY_SLOT(1'b1)) u_ds1 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .br_redirect(br_redirect),
    .br_target(br_target), .exc_req(exc_req), .exc_target(exc_target), .f_instr(f_instr1),
    .f_pc(f_pc1), .d_instr(d_instr1), .d_pc(d_pc1), .d_pc8(d_pc81), .d_valid(d_valid1),
    .d_exc_adel(d_adel1)
  );

  fetch_stage #(.PC_RESET(32'h0000_3000), .IM_WORDS(4096), .DELAY_SLOT(1'b0)) u_ds0 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .br_redirect(br_redirect),
    .br_target(br_target), .exc_req(exc_req), .exc_target(exc_target), .f_instr(f_instr0),
    .f_pc(f_pc0), .d_instr(d_instr0), .d_pc(d_pc0), .d_pc8(d_pc80), .d_valid(d_valid0),
    .d_exc_adel(d_adel0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000;
    for (int k = 0; k < 2; k++) begin
      m_instr[k] = 32'h0;
      m_dpc[k]   = 32'h0;
      m_valid[k] = 1'b0;
      m_adel[k]  = 1'b0;
      m_chk[k]   = 1'b1;
    end
  endtask

  task automatic push_model();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.fpc    = m_pc;
      e.instr  = m_instr[k];
      e.dpc    = m_dpc[k];
      e.valid  = m_valid[k];
      e.adel   = m_adel[k];
      e.chk_pc = m_chk[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        if (k == 0) begin
          check({tag, "_ds1_f_pc"}, f_pc1, e.fpc);
          check({tag, "_ds1_d_instr"}, d_instr1, e.instr);
          check({tag, "_ds1_d_valid"}, 32'(d_valid1), 32'(e.valid));
          check({tag, "_ds1_d_exc_adel"}, 32'(d_adel1), 32'(e.adel));
          if (e.chk_pc) begin
            check({tag, "_ds1_d_pc"}, d_pc1, e.dpc);
            check({tag, "_ds1_d_pc8"}, d_pc81, e.dpc + 32'd8);
          end
        end else begin
          check({tag, "_ds0_f_pc"}, f_pc0, e.fpc);
          check({tag, "_ds0_d_instr"}, d_instr0, e.instr);
          check({tag, "_ds0_d_valid"}, 32'(d_valid0), 32'(e.valid));
          check({tag, "_ds0_d_exc_adel"}, 32'(d_adel0), 32'(e.adel));
          if (e.chk_pc) begin
            check({tag, "_ds0_d_pc"}, d_pc0, e.dpc);
            check({tag, "_ds0_d_pc8"}, d_pc80, e.dpc + 32'd8);
          end
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, advance the model, check after the edge.
  task automatic step(input string tag, input logic s, input logic br,
                      input logic [31:0] bt, input logic ex, input logic [31:0] et);
    logic        flt;
    logic [31:0] word;
    @(negedge clk);
    stall       = s;
    br_redirect = br;
    br_target   = bt;
    exc_req     = ex;
    exc_target  = et;
    flt  = is_fault(m_pc);
    word = flt ? 32'h0 : mem_word(m_pc);
    for (int k = 0; k < 2; k++) begin
      if (ex || (!s && br && k == 1)) begin
        m_instr[k] = 32'h0;
        m_valid[k] = 1'b0;
        m_adel[k]  = 1'b0;
        m_chk[k]   = 1'b0;
      end else if (!s) begin
        m_instr[k] = word;
        m_dpc[k]   = m_pc;
        m_valid[k] = 1'b1;
        m_adel[k]  = flt;
        m_chk[k]   = 1'b1;
      end
    end
    if (ex) m_pc = et;
    else if (!s) m_pc = br ? bt : m_pc + 32'd4;
    push_model();
    @(posedge clk);
    #1;
    pop_compare(tag);
  endtask

  initial begin
    reset_n     = 1'b0;
    stall       = 1'b0;
    br_redirect = 1'b0;
    br_target   = 32'h0;
    exc_req     = 1'b0;
    exc_target  = 32'h0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    push_model();
    pop_compare("reset");
    check("reset_d_pc8", d_pc81, 32'h0000_0008);
    #2 reset_n = 1'b1;

    // Sequential fetch from the reset vector
    step("t1_e1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t1_instr_const", d_instr1, 32'h3C01_1234);
    check("t1_pc8_const", d_pc81, 32'h0000_3008);
    step("t1_e2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t1_fpc_const", f_pc1, 32'h0000_3008);

    // Stall three cycles at 0x3008, then resume
    repeat (3) step("t2_stall", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t2_frozen_fpc", f_pc1, 32'h0000_3008);
    step("t2_resume", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t2_resume_fpc", f_pc1, 32'h0000_300C);

    // Branch from 0x3010 to 0x3100: delay slot kept vs squashed
    step("t3_pre", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("t3_br", 1'b0, 1'b1, 32'h0000_3100, 1'b0, 32'h0);
    check("t3_ds1_dpc_const", d_pc1, 32'h0000_3010);
    check("t3_ds0_valid_const", 32'(d_valid0), 32'd0);
    step("t3_post", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("t3_branch_stalled", 1'b1, 1'b1, 32'h0000_3200, 1'b0, 32'h0);

    // Exception beats stall and branch together
    step("t4_exc", 1'b1, 1'b1, 32'h0000_3200, 1'b1, 32'h0000_4180);
    check("t4_fpc_const", f_pc1, 32'h0000_4180);
    step("t4_handler", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Fetch address errors: misaligned, below base, past end
    step("t5_br_mis", 1'b0, 1'b1, 32'h0000_3102, 1'b0, 32'h0);
    step("t5_mis", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t5_adel_const", 32'(d_adel1), 32'd1);
    check("t5_dpc_const", d_pc1, 32'h0000_3102);
    step("t5_br_low", 1'b0, 1'b1, 32'h0000_2FFC, 1'b0, 32'h0);
    step("t5_low", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("t5_br_high", 1'b0, 1'b1, 32'h0000_7000, 1'b0, 32'h0);
    step("t5_high", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("t5_br_last", 1'b0, 1'b1, 32'h0000_6FFC, 1'b0, 32'h0);
    step("t5_last", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // PC wraps from the top of the address space
    step("wrap_exc", 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    step("wrap_top", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("wrap_fpc_const", f_pc1, 32'h0000_0000);
    step("wrap_zero", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Async reset during a stall with a redirect pending
    step("t6_pre", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3040);
    step("t6_run", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("t6_stall", 1'b1, 1'b1, 32'h0000_3500, 1'b0, 32'h0);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    push_model();
    pop_compare("t6_async");
    #1 reset_n = 1'b1;
    stall       = 1'b0;
    br_redirect = 1'b0;
    step("t6_restart", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t6_instr_const", d_instr1, 32'h3C01_1234);
    step("t6_next", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
